// File: rtl/uart_tx_dev_pkg.sv
// uart_tx_dev_pkg
//   Shared constants for the UART transmitter peripheral and its integration
//   into the Bridge:
//   - register offsets (word index within the 16-byte window);
//   - STATUS and CTRL bit positions;
//   - transmit FSM state encoding;
//   - the window base address;
//   - small helpers for the divisor and FIFO-count fields.
package uart_tx_dev_pkg;

  typedef logic [1:0] reg_off_t;

  // Register offsets, selected by Addr[3:2] of the byte address.
  localparam reg_off_t REG_DATA    = 2'd0;
  localparam reg_off_t REG_STATUS  = 2'd1;
  localparam reg_off_t REG_DIVISOR = 2'd2;
  localparam reg_off_t REG_CTRL    = 2'd3;

  // STATUS bit positions.
  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_CNT_LSB = 3;
  localparam int STAT_CNT_MSB = 5;
  localparam int STAT_OVF     = 6;

  // CTRL bit positions.
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  // Transmit FSM encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Where the Bridge places the UART window (16 bytes, next to the timers).
  localparam logic [31:0] UART_BASE_ADDR    = 32'h0000_7F30;
  localparam logic [31:0] UART_WINDOW_BYTES = 32'd16;

  // A programmed divisor of 0 runs at one clock per bit.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

  // The STATUS count field is only three bits wide; deeper FIFOs read as 7.
  function automatic logic [2:0] sat_count(input logic [31:0] c);
    return (c > 32'd7) ? 3'd7 : c[2:0];
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Synchronous byte FIFO with first-word-fall-through read port.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset (clears pointers)
//     push, din         write request and data; accepted when not full, or
//                       when full and a pop happens in the same cycle
//     pop, dout         read request; dout always shows the head entry
//     full, empty       occupancy flags
//     count             number of stored entries (0..DEPTH)
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Pop is resolved first, so a full FIFO can still take a write in the
  // cycle its head is consumed.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once the
  // pointers are cleared.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/uart_tx_dev.sv
// uart_tx_dev
//   Memory-mapped 8N1 UART transmitter on the Bridge device side.
//   Ports:
//     clk     system clock
//     reset   asynchronous active-low reset
//     Addr    word address [31:2]; only Addr[3:2] (Addr[1:0] here) decoded
//     WE      write strobe, sampled on the rising edge
//     Din     write data
//     Dout    read data, combinational from the register select
//     IRQ     registered level interrupt: irq_en & FIFO empty & FSM idle
//     txd     serial output, idles high
//   Registers: 0 DATA (push byte), 1 STATUS, 2 DIVISOR, 3 CTRL.
module uart_tx_dev
  import uart_tx_dev_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter int unsigned DIV_RESET  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        txd
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Register file.
  logic [15:0] div_q, div_d;
  logic        en_q, en_d;
  logic        irq_en_q, irq_en_d;
  logic        ovf_q, ovf_d;

  // Transmit engine.
  logic [1:0]  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] bit_div_q, bit_div_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        txd_q, txd_d;
  logic        irq_q, irq_d;

  // FIFO interface.
  logic          fsm_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  logic [1:0] reg_sel;
  logic       wr_data, wr_div, wr_ctrl;
  logic       busy, bit_end;
  logic [2:0] cnt_field;
  logic       unused_ok;

  assign reg_sel = Addr[1:0];
  assign wr_data = WE & (reg_sel == REG_DATA);
  assign wr_div  = WE & (reg_sel == REG_DIVISOR);
  assign wr_ctrl = WE & (reg_sel == REG_CTRL);

  assign unused_ok = ^{Addr[29:2], Din[31:16]};

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (wr_data),
    .din   (Din[7:0]),
    .pop   (fsm_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------------------------------------------------------- registers
  always_comb begin
    div_d    = wr_div  ? Din[15:0]         : div_q;
    en_d     = wr_ctrl ? Din[CTRL_EN]      : en_q;
    irq_en_d = wr_ctrl ? Din[CTRL_IRQ_EN]  : irq_en_q;
    ovf_d    = ovf_q;
    if (wr_ctrl) begin
      ovf_d = 1'b0;
    end else if (wr_data && fifo_full && !fsm_pop) begin
      // Only a push that the FIFO actually refuses counts as overflow.
      ovf_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------- FSM
  assign busy    = (state_q != ST_IDLE);
  assign bit_end = (timer_q == 16'd1);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_div_d = bit_div_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    fsm_pop   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en_q && !fifo_empty) begin
          fsm_pop   = 1'b1;
          shift_d   = fifo_dout;
          // The divisor is frozen for the whole frame so that a mid-frame
          // DIVISOR write only affects the next one.
          bit_div_d = eff_div(div_q);
          timer_d   = eff_div(div_q);
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          timer_d   = bit_div_q;
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          timer_d = bit_div_q;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: begin // ST_STOP
        if (bit_end) begin
          timer_d = bit_div_q;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
    endcase
  end

  // txd is registered from the next-state view so the line changes exactly
  // on the edge that enters each bit, with no combinational glitches.
  always_comb begin
    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  assign irq_d = irq_en_q & fifo_empty & (state_q == ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q     <= 16'(DIV_RESET);
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      state_q   <= ST_IDLE;
      timer_q   <= 16'd1;
      bit_div_q <= 16'd1;
      shift_q   <= 8'd0;
      bit_idx_q <= 3'd0;
      txd_q     <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_div_q <= bit_div_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
      irq_q     <= irq_d;
    end
  end

  assign txd = txd_q;
  assign IRQ = irq_q;

  // ---------------------------------------------------------------- read mux
  assign cnt_field = sat_count(32'(fifo_count));

  always_comb begin
    Dout = 32'd0;
    case (reg_sel)
      REG_STATUS: begin
        Dout[STAT_BUSY]                  = busy;
        Dout[STAT_FULL]                  = fifo_full;
        Dout[STAT_EMPTY]                 = fifo_empty;
        Dout[STAT_CNT_MSB:STAT_CNT_LSB]  = cnt_field;
        Dout[STAT_OVF]                   = ovf_q;
      end
      REG_DIVISOR: Dout[15:0] = div_q;
      REG_CTRL: begin
        Dout[CTRL_EN]     = en_q;
        Dout[CTRL_IRQ_EN] = irq_en_q;
      end
      default: Dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_dev.sv
module tb_uart_tx_dev;
  import uart_tx_dev_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [29:0] Addr = '0;
  logic        WE = 1'b0;
  logic [31:0] Din = '0;
  logic [31:0] Dout;
  logic        IRQ;
  logic        txd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_dev #(
    .FIFO_DEPTH (4),
    .DIV_RESET  (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ),
    .txd   (txd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  // One register write; the write lands on the posedge inside the task and
  // the task returns on the following negedge with Addr pointing at STATUS.
  task automatic wr(input logic [1:0] off, input logic [31:0] data);
    @(negedge clk);
    Addr = {28'd0, off};
    Din  = data;
    WE   = 1'b1;
    @(negedge clk);
    WE   = 1'b0;
    Din  = '0;
    Addr = {28'd0, REG_STATUS};
    $display("WR off=%0d data=0x%08h", off, data);
  endtask

  task automatic rd(input logic [1:0] off, output logic [31:0] data);
    @(negedge clk);
    Addr = {28'd0, off};
    #1;
    data = Dout;
    $display("RD off=%0d data=0x%08h", off, data);
  endtask

  // Expected txd for bit slot k of an 8N1 frame (0 start, 1..8 data, 9 stop).
  function automatic logic fbit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  logic [31:0] r;
  logic [7:0]  bytes3 [4];

  initial begin
    // ---------------- reset state
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rd(REG_STATUS, r);  check("rst_status", r, 32'h4);
    rd(REG_DIVISOR, r); check("rst_div", r, 32'd16);
    rd(REG_CTRL, r);    check("rst_ctrl", r, 32'h0);
    rd(REG_DATA, r);    check("rst_data", r, 32'h0);
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_irq", {31'd0, IRQ}, 32'd0);

    // ---------------- single frame 0xA5, 4 clocks per bit
    wr(REG_DIVISOR, 32'd4);
    rd(REG_DIVISOR, r); check("div_rb", r, 32'd4);
    wr(REG_CTRL, 32'd1);
    wr(REG_DATA, 32'hA5);
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      check($sformatf("a5_txd_%0d", k), {31'd0, txd}, {31'd0, fbit(8'hA5, k / 4)});
      check($sformatf("a5_busy_%0d", k), {31'd0, Dout[0]}, 32'd1);
      @(negedge clk);
    end
    check("a5_end_txd", {31'd0, txd}, 32'd1);
    check("a5_end_busy", {31'd0, Dout[0]}, 32'd0);

    // ---------------- overflow and back-to-back frames
    wr(REG_DIVISOR, 32'd2);
    wr(REG_CTRL, 32'd0);
    for (int i = 0; i < 6; i++) wr(REG_DATA, 32'h11 + 32'(i));
    rd(REG_STATUS, r); check("ovf_status", r, 32'h62);
    wr(REG_CTRL, 32'd0);
    rd(REG_STATUS, r); check("ovf_clear", r, 32'h22);
    for (int i = 0; i < 4; i++) bytes3[i] = 8'h11 + 8'(i);
    wr(REG_CTRL, 32'd1);
    @(negedge clk);
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 20; k++) begin
        check($sformatf("b2b_f%0d_%0d", f, k), {31'd0, txd}, {31'd0, fbit(bytes3[f], k / 2)});
        @(negedge clk);
      end
      check($sformatf("b2b_gap_%0d", f), {31'd0, txd}, 32'd1);
      @(negedge clk);
    end
    rd(REG_STATUS, r); check("b2b_done", r, 32'h4);

    // ---------------- IRQ behaviour
    wr(REG_CTRL, 32'd3);
    repeat (3) @(negedge clk);
    check("irq_idle", {31'd0, IRQ}, 32'd1);
    wr(REG_DATA, 32'h3C);
    @(negedge clk);
    check("irq_drop", {31'd0, IRQ}, 32'd0);
    repeat (20) @(negedge clk);
    check("irq_stop_end", {31'd0, IRQ}, 32'd0);
    check("irq_stop_busy", {31'd0, Dout[0]}, 32'd0);
    @(negedge clk);
    check("irq_rise", {31'd0, IRQ}, 32'd1);
    wr(REG_CTRL, 32'd1);
    @(negedge clk);
    check("irq_off", {31'd0, IRQ}, 32'd0);
    repeat (5) @(negedge clk);
    check("irq_stays_off", {31'd0, IRQ}, 32'd0);

    // ---------------- disable mid-frame
    wr(REG_CTRL, 32'd0);
    wr(REG_DATA, 32'h5A);
    wr(REG_DATA, 32'hC3);
    wr(REG_CTRL, 32'd1);
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      check($sformatf("dis_txd_%0d", k), {31'd0, txd}, {31'd0, fbit(8'h5A, k / 2)});
      if (k == 7) begin
        Addr = {28'd0, REG_CTRL};
        Din  = 32'd0;
        WE   = 1'b1;
      end else if (k == 8) begin
        WE   = 1'b0;
        Addr = {28'd0, REG_STATUS};
        $display("WR off=3 data=0x00000000 (mid-frame)");
      end
      @(negedge clk);
    end
    for (int k = 0; k < 10; k++) begin
      check($sformatf("dis_hold_%0d", k), {31'd0, txd}, 32'd1);
      @(negedge clk);
    end
    rd(REG_STATUS, r); check("dis_status", r, 32'h08);
    wr(REG_CTRL, 32'd1);
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      check($sformatf("resume_txd_%0d", k), {31'd0, txd}, {31'd0, fbit(8'hC3, k / 2)});
      @(negedge clk);
    end

    // ---------------- asynchronous reset mid-frame
    wr(REG_DATA, 32'h00);
    wr(REG_DATA, 32'h77);
    repeat (11) @(negedge clk);
    check("ar_bit5_txd", {31'd0, txd}, 32'd0);
    check("ar_bit5_status", Dout, 32'h09);
    #2 reset = 1'b0;
    #1 check("ar_txd_async", {31'd0, txd}, 32'd1);
    #1 reset = 1'b1;
    rd(REG_STATUS, r);  check("ar_status", r, 32'h4);
    rd(REG_DIVISOR, r); check("ar_div", r, 32'd16);
    rd(REG_CTRL, r);    check("ar_ctrl", r, 32'h0);
    check("ar_txd", {31'd0, txd}, 32'd1);
    check("ar_irq", {31'd0, IRQ}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
